// File: rtl/stk_pkg.sv
// stk_pkg: shared widths, types and register-stage structs for the
// prev-pointer SRAM arbiter slice.
//   ENGS_N  - number of requesting engines
//   BANKS_N - number of prev-pointer SRAM banks
//   engid_t / bank_id_t / line_id_t / ptr_t - field types used on the ports
//   sram_cmd_t - one registered bank command
//   rd_tag_t   - one in-flight read tag (valid + owning engine)
package stk_pkg;

  localparam int ENGS_N  = 4;
  localparam int BANKS_N = 4;
  localparam int ENG_W   = $clog2(ENGS_N);
  localparam int BANK_W  = $clog2(BANKS_N);
  localparam int LINE_W  = 6;
  localparam int PTR_W   = 16;

  typedef logic [ENG_W-1:0]  engid_t;
  typedef logic [BANK_W-1:0] bank_id_t;
  typedef logic [LINE_W-1:0] line_id_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef struct packed {
    logic     ce;
    logic     oe;
    line_id_t addr;
    ptr_t     din;
  } sram_cmd_t;

  typedef struct packed {
    logic   vld;
    engid_t eng;
  } rd_tag_t;

endpackage

// File: rtl/stk_mem_arb_if.sv
// stk_mem_arb_if: bundles the engine request/response bus and the
// per-bank SRAM command/data bus of stk_mem_arb.
//   slave  modport - the arbiter (consumes requests and SRAM read data)
//   master modport - the engines plus SRAM (produce requests and read data)
interface stk_mem_arb_if #(
  parameter int ENGS_N  = stk_pkg::ENGS_N,
  parameter int BANKS_N = stk_pkg::BANKS_N
);
  import stk_pkg::*;

  // Engine side
  logic     [ENGS_N-1:0] i_req_vld;
  bank_id_t [ENGS_N-1:0] i_req_bankid;
  line_id_t [ENGS_N-1:0] i_req_addr;
  logic     [ENGS_N-1:0] i_req_wr;
  ptr_t     [ENGS_N-1:0] i_req_wdat;
  logic     [ENGS_N-1:0] o_req_rdy;
  logic     [ENGS_N-1:0] o_rsp_vld;
  ptr_t     [ENGS_N-1:0] o_rsp_dat;

  // SRAM side
  logic     [BANKS_N-1:0] o_sram_ce;
  logic     [BANKS_N-1:0] o_sram_oe;
  line_id_t [BANKS_N-1:0] o_sram_addr;
  ptr_t     [BANKS_N-1:0] o_sram_din;
  ptr_t     [BANKS_N-1:0] i_sram_dout;

  modport slave (
    input  i_req_vld, i_req_bankid, i_req_addr, i_req_wr, i_req_wdat, i_sram_dout,
    output o_req_rdy, o_rsp_vld, o_rsp_dat,
    output o_sram_ce, o_sram_oe, o_sram_addr, o_sram_din
  );

  modport master (
    output i_req_vld, i_req_bankid, i_req_addr, i_req_wr, i_req_wdat, i_sram_dout,
    input  o_req_rdy, o_rsp_vld, o_rsp_dat,
    input  o_sram_ce, o_sram_oe, o_sram_addr, o_sram_din
  );

endinterface

// File: rtl/stk_rr_arb.sv
// stk_rr_arb: N-way round-robin arbiter with an internal search pointer.
//   clk, rst - clock and synchronous active-high reset
//   req      - request vector
//   gnt      - one-hot grant (combinational)
//   gnt_idx  - index of the granted requester (valid when gnt_any)
//   gnt_any  - a grant was issued this cycle
// The search starts at the pointer; after a grant the pointer moves to the
// requester just past the winner, so each requester waits at most N-1 grants.
module stk_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr_q;
  int               cand;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr_q) + i) % N;
      if (!gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt_idx   = IDX_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/stk_mem_arb.sv
// stk_mem_arb: arbitrates ENGS_N engines onto BANKS_N single-port
// prev-pointer SRAM banks, one round-robin arbiter per bank.
//   clk - sole clock, rising edge
//   rst - synchronous active-high reset
//   bus - stk_mem_arb_if.slave: engine requests/grants/responses and the
//         registered per-bank SRAM command plus SRAM read data
// Timing: accept in T -> bank command in T+1 -> read data and o_rsp_vld in T+2.
module stk_mem_arb #(
  parameter int ENGS_N  = stk_pkg::ENGS_N,
  parameter int BANKS_N = stk_pkg::BANKS_N
) (
  input  logic          clk,
  input  logic          rst,
  stk_mem_arb_if.slave  bus
);
  import stk_pkg::*;

  logic [ENGS_N-1:0] bank_req [BANKS_N];
  logic [ENGS_N-1:0] bank_gnt [BANKS_N];
  engid_t            gnt_idx  [BANKS_N];
  logic              gnt_any  [BANKS_N];

  sram_cmd_t cmd_q  [BANKS_N];
  rd_tag_t   tag1_q [BANKS_N];  // read issued to SRAM this cycle
  rd_tag_t   tag2_q [BANKS_N];  // SRAM data for that read is on i_sram_dout

  logic [ENGS_N-1:0] rdy;
  logic [ENGS_N-1:0] rsp_vld;
  ptr_t [ENGS_N-1:0] rsp_dat;

  // Steer each engine's request to its target bank; reset masks all requests
  // so nothing is granted (or accepted) while rst is high.
  always_comb begin
    for (int b = 0; b < BANKS_N; b++) begin
      for (int e = 0; e < ENGS_N; e++) begin
        bank_req[b][e] = bus.i_req_vld[e] && !rst &&
                         (bus.i_req_bankid[e] == bank_id_t'(b));
      end
    end
  end

  for (genvar b = 0; b < BANKS_N; b++) begin : g_bank
    stk_rr_arb #(.N(ENGS_N)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bank_req[b]),
      .gnt     (bank_gnt[b]),
      .gnt_idx (gnt_idx[b]),
      .gnt_any (gnt_any[b])
    );
  end

  // An engine targets one bank per cycle, so OR-ing bank grants is exact.
  always_comb begin
    rdy = '0;
    for (int b = 0; b < BANKS_N; b++) begin
      rdy = rdy | bank_grt_or_zero(b);
    end
  end

  function automatic logic [ENGS_N-1:0] bank_grt_or_zero(input int b);
    return bank_gnt[b];
  endfunction

  assign bus.o_req_rdy = rdy;

  // NOTE: only the small command/tag registers are reset; the SRAM array is
  // never cleared, and dropping the tags is what discards in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKS_N; b++) begin
        cmd_q[b]  <= '0;
        tag1_q[b] <= '0;
        tag2_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < BANKS_N; b++) begin
        cmd_q[b].ce <= gnt_any[b];
        cmd_q[b].oe <= gnt_any[b] && !bus.i_req_wr[gnt_idx[b]];
        // Address/data hold their last value on idle cycles (ce gates them).
        if (gnt_any[b]) begin
          cmd_q[b].addr <= bus.i_req_addr[gnt_idx[b]];
          cmd_q[b].din  <= bus.i_req_wdat[gnt_idx[b]];
        end
        tag1_q[b].vld <= gnt_any[b] && !bus.i_req_wr[gnt_idx[b]];
        tag1_q[b].eng <= gnt_idx[b];
        tag2_q[b]     <= tag1_q[b];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < BANKS_N; b++) begin
      bus.o_sram_ce[b]   = cmd_q[b].ce;
      bus.o_sram_oe[b]   = cmd_q[b].oe;
      bus.o_sram_addr[b] = cmd_q[b].addr;
      bus.o_sram_din[b]  = cmd_q[b].din;
    end
  end

  // Route each bank's returning read data to its owner; idle engines see 0.
  always_comb begin
    rsp_vld = '0;
    rsp_dat = '0;
    for (int b = 0; b < BANKS_N; b++) begin
      if (tag2_q[b].vld) begin
        rsp_vld[tag2_q[b].eng] = 1'b1;
        rsp_dat[tag2_q[b].eng] = bus.i_sram_dout[b];
      end
    end
  end

  assign bus.o_rsp_vld = rsp_vld;
  assign bus.o_rsp_dat = rsp_dat;

endmodule

// File: tb/tb_stk_mem_arb.sv
// tb_stk_mem_arb: directed bench for stk_mem_arb with a behavioural SRAM,
// an expected-response scoreboard and a monitor that compares responses.
module tb_stk_mem_arb;
  import stk_pkg::*;

  localparam int LINES = 2 ** LINE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stk_mem_arb_if bus ();

  stk_mem_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Power-on/reset content of every SRAM line.
  function automatic ptr_t pat(input int b, input int a);
    return ptr_t'(32'hA000 + b * 256 + a);
  endfunction

  // Behavioural SRAM: read data appears the cycle after ce&oe.
  ptr_t mem [BANKS_N][LINES];
  always @(posedge clk) begin
    for (int b = 0; b < BANKS_N; b++) begin
      if (rst) begin
        for (int a = 0; a < LINES; a++) mem[b][a] <= pat(b, a);
        bus.i_sram_dout[b] <= '0;
      end else if (bus.o_sram_ce[b]) begin
        if (bus.o_sram_oe[b]) bus.i_sram_dout[b] <= mem[b][bus.o_sram_addr[b]];
        else                  mem[b][bus.o_sram_addr[b]] <= bus.o_sram_din[b];
      end
    end
  end

  // Scoreboard: one queue of expected read responses per engine.
  typedef struct {
    ptr_t dat;
    int   cyc;
  } exp_t;
  exp_t exp_q [ENGS_N][$];

  task automatic expect_rsp(input int e, input ptr_t d, input int c);
    exp_t x;
    x.dat = d;
    x.cyc = c;
    exp_q[e].push_back(x);
  endtask

  // Monitor: a response is due exactly when the head entry's cycle arrives.
  always @(negedge clk) begin : mon
    exp_t x;
    logic due;
    for (int e = 0; e < ENGS_N; e++) begin
      due = (exp_q[e].size() != 0) && (exp_q[e][0].cyc == cyc);
      check($sformatf("rsp_vld_e%0d", e), bus.o_rsp_vld[e], due);
      if (due) begin
        x = exp_q[e].pop_front();
        check($sformatf("rsp_dat_e%0d", e), bus.o_rsp_dat[e], x.dat);
      end else begin
        check($sformatf("rsp_dat_idle_e%0d", e), bus.o_rsp_dat[e], 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.i_req_vld = '0;
    bus.i_req_wr  = '0;
  endtask

  task automatic set_req(input int e, input int b, input int a, input logic wr, input ptr_t d);
    bus.i_req_vld[e]    = 1'b1;
    bus.i_req_bankid[e] = bank_id_t'(b);
    bus.i_req_addr[e]   = line_id_t'(a);
    bus.i_req_wr[e]     = wr;
    bus.i_req_wdat[e]   = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_all();
    bus.i_req_bankid = '0;
    bus.i_req_addr   = '0;
    bus.i_req_wdat   = '0;

    // Reset held two cycles with every engine requesting bank 0.
    for (int e = 0; e < ENGS_N; e++) set_req(e, 0, e + 1, 1'b0, '0);
    repeat (2) begin
      step();
      @(negedge clk);
      check("rst_rdy", bus.o_req_rdy, 0);
      check("rst_ce", bus.o_sram_ce, 0);
      check("rst_rsp_vld", bus.o_rsp_vld, 0);
    end

    // Release, then 8 cycles of 4-way contention on bank 0.
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      @(negedge clk);
      check("cont_rdy", bus.o_req_rdy, 1 << (i % 4));
      check("cont_ce", bus.o_sram_ce, (i == 0) ? 0 : 4'b0001);
      if (i > 0) check("cont_addr", bus.o_sram_addr[0], ((i - 1) % 4) + 1);
      expect_rsp(i % 4, pat(0, (i % 4) + 1), cyc + 2);
    end
    step();
    idle_all();
    @(negedge clk);
    check("cont_last_ce", bus.o_sram_ce, 4'b0001);
    check("cont_last_addr", bus.o_sram_addr[0], 4);
    repeat (2) step();

    // Parallel banks: eng0 -> bank0 line 3, eng1 -> bank1 line 4.
    set_req(0, 0, 3, 1'b0, '0);
    set_req(1, 1, 4, 1'b0, '0);
    @(negedge clk);
    check("par_rdy", bus.o_req_rdy, 4'b0011);
    expect_rsp(0, pat(0, 3), cyc + 2);
    expect_rsp(1, pat(1, 4), cyc + 2);
    step();
    idle_all();
    @(negedge clk);
    check("par_ce", bus.o_sram_ce, 4'b0011);
    check("par_oe", bus.o_sram_oe, 4'b0011);
    check("par_addr0", bus.o_sram_addr[0], 3);
    check("par_addr1", bus.o_sram_addr[1], 4);
    repeat (2) step();

    // Read-after-write: eng2 writes bank1 line 5, eng3 reads it next cycle.
    set_req(2, 1, 5, 1'b1, 16'h002A);
    @(negedge clk);
    check("raw_wr_rdy", bus.o_req_rdy, 4'b0100);
    step();
    idle_all();
    set_req(3, 1, 5, 1'b0, '0);
    @(negedge clk);
    check("raw_rd_rdy", bus.o_req_rdy, 4'b1000);
    check("raw_wr_ce", bus.o_sram_ce, 4'b0010);
    check("raw_wr_oe", bus.o_sram_oe, 4'b0000);
    check("raw_wr_din", bus.o_sram_din[1], 16'h002A);
    expect_rsp(3, 16'h002A, cyc + 2);
    step();
    idle_all();
    @(negedge clk);
    check("raw_rd_ce", bus.o_sram_ce, 4'b0010);
    check("raw_rd_oe", bus.o_sram_oe, 4'b0010);
    repeat (2) step();

    // Write only: eng1 writes bank2 line 7; no response may follow.
    set_req(1, 2, 7, 1'b1, 16'h1234);
    @(negedge clk);
    check("wr_rdy", bus.o_req_rdy, 4'b0010);
    step();
    idle_all();
    @(negedge clk);
    check("wr_ce", bus.o_sram_ce, 4'b0100);
    check("wr_oe", bus.o_sram_oe, 4'b0000);
    check("wr_addr", bus.o_sram_addr[2], 7);
    check("wr_din", bus.o_sram_din[2], 16'h1234);
    step();
    @(negedge clk);
    check("wr_no_rsp", bus.o_rsp_vld, 0);
    step();

    // Mid-operation reset: read accepted at T, rst high at T+1.
    set_req(0, 3, 1, 1'b0, 16'h5555);
    @(negedge clk);
    check("mrst_rd_rdy", bus.o_req_rdy, 4'b0001);
    step();
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    check("mrst_cmd_ce", bus.o_sram_ce, 4'b1000);
    step();
    for (int e = 0; e < ENGS_N; e++) set_req(e, 3, 0, 1'b0, '0);
    @(negedge clk);
    check("mrst_rsp_vld", bus.o_rsp_vld, 0);
    check("mrst_ce", bus.o_sram_ce, 0);
    check("mrst_oe", bus.o_sram_oe, 0);
    check("mrst_addr", bus.o_sram_addr, 0);
    check("mrst_din3", bus.o_sram_din[3], 0);
    check("mrst_rdy", bus.o_req_rdy, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ptr_rdy", bus.o_req_rdy, 4'b0001);
    expect_rsp(0, pat(3, 0), cyc + 2);
    step();
    idle_all();
    repeat (3) step();

    for (int e = 0; e < ENGS_N; e++)
      check($sformatf("sb_drain_e%0d", e), exp_q[e].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
